mult_div_unit: RTL and testbench

Parametrised signed/unsigned multiply-divide unit for the multi-cycle MIPS datapath, replacing the unsigned-only multiplier. It executes MULTU, MULT, DIVU and DIV with a radix-2 iterative datapath, one bit per cycle. It returns a double-width result as HI/LO halves and uses a start/busy/valid handshake toward the main controller.

---
 rtl/mult_div_pkg.sv | 8 +
 rtl/mult_div_datapath.sv | 67 ++++++
 rtl/mult_div_unit.sv | 71 +++++++
 tb/tb_mult_div_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: op encodings and FSM state type for the multiply-divide unit
package mult_div_pkg;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/mult_div_datapath.sv
// mult_div_datapath: radix-2 shift-add multiply / restoring divide with sign handling
module mult_div_datapath
    import mult_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  init,
    input  logic                  step,
    input  logic                  fix,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  div_by_zero
);
    localparam int W = DATA_WIDTH;
    logic [W-1:0] acc, mq, dvs, orig, diff;
    logic is_div, neg_lo, neg_hi, dz, sgn, sa, sb, ge;
    logic [W:0] sum, sh;
    logic [2*W-1:0] prod;
    // operand signs, one iteration of add-shift / compare-subtract, and the signed product
    always_comb begin
        sgn  = (op == OP_MULT) || (op == OP_DIV);
        sa   = sgn & operand1[W-1];
        sb   = sgn & operand2[W-1];
        sum  = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : '0);
        sh   = {acc, mq[W-1]};
        ge   = sh >= {1'b0, dvs};
        diff = sh[W-1:0] - dvs;
        prod = neg_lo ? -{acc, mq} : {acc, mq};
    end
    // magnitudes are latched on init, iterated on step, sign-corrected into hi/lo on fix
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc         <= '0;
            mq          <= '0;
            dvs         <= '0;
            orig        <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (init) begin
            acc    <= '0;
            mq     <= sa ? -operand1 : operand1;
            dvs    <= sb ? -operand2 : operand2;
            orig   <= operand1;
            is_div <= (op == OP_DIVU) || (op == OP_DIV);
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            dz     <= ((op == OP_DIVU) || (op == OP_DIV)) && (operand2 == '0);
        end else if (step) begin
            acc <= is_div ? (ge ? diff : sh[W-1:0]) : sum[W:1];
            mq  <= is_div ? {mq[W-2:0], ge} : {sum[0], mq[W-1:1]};
        end else if (fix) begin
            div_by_zero <= dz;
            lo <= !is_div ? prod[W-1:0] : dz ? '1 : neg_lo ? -mq : mq;
            hi <= !is_div ? prod[2*W-1:W] : dz ? orig : neg_hi ? -acc : acc;
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULTU/MULT/DIVU/DIV unit with start/busy/valid handshake
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  valid,
    output logic                  div_by_zero
);
    localparam int CW = $clog2(DATA_WIDTH);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic init, step, fix;
    assign busy = state != IDLE;
    // next-state and datapath strobes
    always_comb begin
        state_n = state;
        init    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state)
            IDLE: begin
                init    = start;
                state_n = start ? CALC : IDLE;
            end
            CALC: begin
                step    = 1'b1;
                state_n = (cnt == CW'(DATA_WIDTH - 1)) ? FIX : CALC;
            end
            FIX: begin
                fix     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // state, iteration counter and the completion pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= step ? cnt + CW'(1) : '0;
            valid <= fix;
        end
    end
    mult_div_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_dp (
        .CLK         (CLK),
        .RST         (RST),
        .init        (init),
        .step        (step),
        .fix         (fix),
        .op          (op),
        .operand1    (Operand1),
        .operand2    (Operand2),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit at DATA_WIDTH=32
module tb_mult_div_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t0;
    } exp_t;
    logic CLK = 1'b0, RST = 1'b1, start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] op1 = '0, op2 = '0;
    logic [31:0] hi, lo;
    logic busy, valid, div_by_zero;
    int cyc = 0, t_go = -1000, total = 0, bad = 0;
    logic rst_q = 1'b0, armed = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic m_dz = 1'b0;
    exp_t q[$];

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .Operand1(op1), .Operand2(op2),
        .hi(hi), .lo(lo), .busy(busy), .valid(valid), .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        e.dz = 1'b0;
        e.t0 = 0;
        e.hi = '0;
        e.lo = '0;
        if (o == 2'b00) begin
            p = {32'b0, a} * {32'b0, b};
            {e.hi, e.lo} = p;
        end else if (o == 2'b01) begin
            p = longint'(int'(a)) * longint'(int'(b));
            {e.hi, e.lo} = p;
        end else if (b == 0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else if (o == 2'b10) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 0;
        end else begin
            e.lo = int'(a) / int'(b);
            e.hi = int'(a) % int'(b);
        end
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(o, a, b);
        e.t0 = cyc;
        q.push_back(e);
        t_go = cyc;
        start = 1'b1;
        op = o;
        op1 = a;
        op2 = b;
        @(posedge CLK); #1;
        start = 1'b0;
        op = 2'($urandom);
        op1 = $urandom;
        op2 = $urandom;
    endtask

    task automatic wait_until(input int c);
        int n = 0;
        while (cyc < c && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("wait_bound", 64'(n < 200), 64'(1));
    endtask

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST;
    end

    // compares every cycle: busy window, valid pulses against the queue, hi/lo hold
    always @(negedge CLK) begin
        exp_t e;
        if (rst_q) begin
            armed = 1'b1;
            m_hi = '0;
            m_lo = '0;
            m_dz = 1'b0;
            q.delete();
            t_go = -1000;
        end
        if (armed) begin
            chk("busy", 64'(busy), 64'(cyc > t_go && cyc < t_go + 34));
            if (valid) begin
                if (q.size() == 0) chk("spurious_valid", 64'(valid), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("latency", 64'(cyc - e.t0), 64'(34));
                    m_hi = e.hi;
                    m_lo = e.lo;
                    m_dz = e.dz;
                end
            end
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        start = 1'b1;
        op = 2'b00;
        op1 = 32'd2;
        op2 = 32'd3;
        @(posedge CLK); #1;
        RST = 1'b0;
        start = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_until(t_go + 34);
        issue(2'b01, -32'sd3, 32'd7);
        wait_until(t_go + 34);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_until(t_go + 34);
        issue(2'b11, -32'sd7, 32'd2);
        wait_until(t_go + 34);
        issue(2'b10, 32'd7, 32'd2);
        wait_until(t_go + 34);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_until(t_go + 34);
        issue(2'b10, 32'h1234, 32'd0);
        wait_until(t_go + 34);
        issue(2'b00, 32'd2, 32'd3);
        wait_until(t_go + 34);
        issue(2'b11, 32'h8000_0001, 32'd0);
        wait_until(t_go + 34);
        issue(2'b10, 32'd100, 32'd7);
        wait_until(t_go + 5);
        start = 1'b1;
        op = 2'b01;
        op1 = 32'd9;
        op2 = 32'd11;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_until(t_go + 34);
        issue(2'b11, 32'd100, -32'sd7);
        wait_until(t_go + 10);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            issue(2'(i), $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom);
            wait_until(t_go + 34);
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("pending", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
